// File: rtl/gaus_cordic_mult.sv
// Box-Muller output stage: quarter-wave ROM addressing, sign fold, radius multiply, round/saturate.
// Optional saturation counter (ports iclr/osat_cnt) enabled by defining GAUS_CORDIC_MULT_SAT_CNT_EN.
module gaus_cordic_mult #(
  parameter int unsigned pTAB_LAT = 2,
  parameter int unsigned pRAD_W   = 16,
  parameter int unsigned pDAT_W   = 16,
  parameter int unsigned pSHIFT   = 19
) (
  input  logic                     iclk,
  input  logic                     ireset_n,
  input  logic                     iclkena,
  input  logic                     ival,
  input  logic [10:0]              iphase,
  input  logic [pRAD_W-1:0]        iradius,
  output logic                     otab_clkena,
  output logic [8:0]               otab_cos_addr,
  output logic [8:0]               otab_sin_addr,
  input  logic [17:0]              itab_cos,
  input  logic [17:0]              itab_sin,
  output logic                     oval,
  output logic signed [pDAT_W-1:0] ox,
  output logic signed [pDAT_W-1:0] oy
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
  ,
  input  logic                     iclr,
  output logic [15:0]              osat_cnt
`endif
);

  localparam int unsigned DLY_N  = pTAB_LAT + 1;
  localparam int unsigned PROD_W = 19 + pRAD_W + 1;
  localparam logic signed [PROD_W-1:0] RND     = PROD_W'(64'sd1 <<< (pSHIFT - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (pDAT_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX;

  assign otab_clkena = iclkena;

  // Stage 1: ROM addressing; odd quadrants swap the cos/sin indices.
  logic [8:0] quarter_idx, quarter_inv, cos_addr_d, sin_addr_d;

  always_comb begin
    quarter_idx = iphase[8:0];
    quarter_inv = 9'd511 - quarter_idx;
    cos_addr_d  = iphase[9] ? quarter_inv : quarter_idx;
    sin_addr_d  = iphase[9] ? quarter_idx : quarter_inv;
  end

  logic [1:0]        quad_q [DLY_N];
  logic [pRAD_W-1:0] rad_q  [DLY_N];
  logic [DLY_N-1:0]  vld_q;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      otab_cos_addr <= '0;
      otab_sin_addr <= '0;
      vld_q         <= '0;
      for (int i = 0; i < DLY_N; i++) begin
        quad_q[i] <= '0;
        rad_q[i]  <= '0;
      end
    end else if (iclkena) begin
      otab_cos_addr <= cos_addr_d;
      otab_sin_addr <= sin_addr_d;
      vld_q         <= {vld_q[DLY_N-2:0], ival};
      quad_q[0]     <= iphase[10:9];
      rad_q[0]      <= iradius;
      for (int i = 1; i < DLY_N; i++) begin
        quad_q[i] <= quad_q[i-1];
        rad_q[i]  <= rad_q[i-1];
      end
    end
  end

  // Stage 2: sign fold of the ROM magnitudes, side data taken from the aligned tap.
  logic [1:0]         quad_tap;
  logic signed [18:0] cos_ext, sin_ext, cos_fold_d, sin_fold_d;
  logic signed [18:0] cos_fold_q, sin_fold_q;
  logic [pRAD_W-1:0]  rad_fold_q;
  logic               vld_fold_q;

  assign quad_tap = quad_q[pTAB_LAT];

  always_comb begin
    cos_ext    = signed'({1'b0, itab_cos});
    sin_ext    = signed'({1'b0, itab_sin});
    cos_fold_d = (quad_tap[1] ^ quad_tap[0]) ? -cos_ext : cos_ext;
    sin_fold_d = quad_tap[1] ? -sin_ext : sin_ext;
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      cos_fold_q <= '0;
      sin_fold_q <= '0;
      rad_fold_q <= '0;
      vld_fold_q <= 1'b0;
    end else if (iclkena) begin
      cos_fold_q <= cos_fold_d;
      sin_fold_q <= sin_fold_d;
      rad_fold_q <= rad_q[pTAB_LAT];
      vld_fold_q <= vld_q[pTAB_LAT];
    end
  end

  // Stage 3: signed x zero-extended radius, full-width product.
  logic signed [pRAD_W:0]   rad_s;
  logic signed [PROD_W-1:0] prod_x_d, prod_y_d, prod_x_q, prod_y_q;
  logic                     vld_prod_q;

  always_comb begin
    rad_s    = signed'({1'b0, rad_fold_q});
    prod_x_d = PROD_W'(cos_fold_q) * PROD_W'(rad_s);
    prod_y_d = PROD_W'(sin_fold_q) * PROD_W'(rad_s);
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      prod_x_q   <= '0;
      prod_y_q   <= '0;
      vld_prod_q <= 1'b0;
    end else if (iclkena) begin
      prod_x_q   <= prod_x_d;
      prod_y_q   <= prod_y_d;
      vld_prod_q <= vld_fold_q;
    end
  end

  // Stage 4: round half-up, arithmetic shift, symmetric saturation. Returns {sat, value}.
  function automatic logic [pDAT_W:0] round_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    shifted = (prod + RND) >>> pSHIFT;
    if (shifted > SAT_MAX) begin
      round_sat = {1'b1, SAT_MAX[pDAT_W-1:0]};
    end else if (shifted < SAT_MIN) begin
      round_sat = {1'b1, SAT_MIN[pDAT_W-1:0]};
    end else begin
      round_sat = {1'b0, shifted[pDAT_W-1:0]};
    end
  endfunction

  logic [pDAT_W:0] res_x, res_y;

  always_comb begin
    res_x = round_sat(prod_x_q);
    res_y = round_sat(prod_y_q);
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      oval <= 1'b0;
      ox   <= '0;
      oy   <= '0;
    end else if (iclkena) begin
      oval <= vld_prod_q;
      if (vld_prod_q) begin
        ox <= res_x[pDAT_W-1:0];
        oy <= res_y[pDAT_W-1:0];
      end
    end
  end

`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  // Counts once per saturated output pair, sticking at full scale; clear has priority.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      sat_cnt_q <= '0;
    end else if (iclkena) begin
      if (iclr) begin
        sat_cnt_q <= '0;
      end else if (vld_prod_q && (res_x[pDAT_W] || res_y[pDAT_W]) && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign osat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_gaus_cordic_mult.sv
// Bench for gaus_cordic_mult: behavioural ROM, slot scoreboard and an arithmetic golden model.
module tb_gaus_cordic_mult;

  localparam int  DAT_W   = 14;
  localparam int  DAT_MAX = (1 << (DAT_W - 1)) - 1;
  localparam int  LAT     = 5;
  localparam real PI      = 3.14159265358979323846;

  logic              iclk = 1'b0;
  logic              ireset_n, iclkena, ival;
  logic [10:0]       iphase;
  logic [15:0]       iradius;
  logic              otab_clkena;
  logic [8:0]        otab_cos_addr, otab_sin_addr;
  logic [17:0]       itab_cos, itab_sin;
  logic              oval;
  logic signed [13:0] ox, oy;
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
  logic              iclr;
  logic [15:0]       osat_cnt;
  int                exp_cnt;
`endif

  always #5 iclk = ~iclk;

  gaus_cordic_mult #(
    .pTAB_LAT (2),
    .pRAD_W   (16),
    .pDAT_W   (DAT_W),
    .pSHIFT   (19)
  ) dut (
    .iclk          (iclk),
    .ireset_n      (ireset_n),
    .iclkena       (iclkena),
    .ival          (ival),
    .iphase        (iphase),
    .iradius       (iradius),
    .otab_clkena   (otab_clkena),
    .otab_cos_addr (otab_cos_addr),
    .otab_sin_addr (otab_sin_addr),
    .itab_cos      (itab_cos),
    .itab_sin      (itab_sin),
    .oval          (oval),
    .ox            (ox),
    .oy            (oy)
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    ,
    .iclr          (iclr),
    .osat_cnt      (osat_cnt)
`endif
  );

  // Quarter-wave cosine table, two-deep read pipeline gated by the ROM clock enable.
  int          tab [512];
  logic [17:0] rom_c1, rom_c2, rom_s1, rom_s2;

  always @(posedge iclk) begin
    if (otab_clkena) begin
      rom_c1 <= 18'(tab[otab_cos_addr]);
      rom_s1 <= 18'(tab[otab_sin_addr]);
      rom_c2 <= rom_c1;
      rom_s2 <= rom_s1;
    end
  end

  assign itab_cos = rom_c2;
  assign itab_sin = rom_s2;

  typedef struct {
    logic        v;
    logic [10:0] ph;
    int          r;
  } slot_t;

  slot_t  slots[$];
  int     n_cmp = 0;
  int     n_err = 0;
  logic   exp_val;
  longint exp_x, exp_y, exp_ca, exp_sa;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint round_sat(input longint p, output bit sat);
    longint v;
    v   = (p + 64'sd262144) >>> 19;
    sat = 1'b0;
    if (v > DAT_MAX) begin
      v   = DAT_MAX;
      sat = 1'b1;
    end else if (v < -DAT_MAX) begin
      v   = -DAT_MAX;
      sat = 1'b1;
    end
    return v;
  endfunction

  // Full-circle cos/sin assembled from the quarter table by quadrant, then scaled by r.
  function automatic void model(input logic [10:0] ph, input int r,
                                output longint x, output longint y, output bit sat);
    longint a, c, s;
    bit     sx, sy;
    a = longint'(ph[8:0]);
    case (ph[10:9])
      2'd0:    begin c =  tab[a];       s =  tab[511 - a]; end
      2'd1:    begin c = -tab[511 - a]; s =  tab[a];       end
      2'd2:    begin c = -tab[a];       s = -tab[511 - a]; end
      default: begin c =  tab[511 - a]; s = -tab[a];       end
    endcase
    x   = round_sat(c * r, sx);
    y   = round_sat(s * r, sy);
    sat = sx | sy;
  endfunction

  task automatic step(input logic en, input logic v, input logic [10:0] ph, input int r);
    slot_t  s;
    longint mx, my;
    bit     msat;
    iclkena = en;
    ival    = v;
    iphase  = ph;
    iradius = 16'(r);
    @(posedge iclk);
    #1;
    if (en) begin
      exp_ca = ph[9] ? 511 - longint'(ph[8:0]) : longint'(ph[8:0]);
      exp_sa = 511 - exp_ca;
      slots.push_back('{v: v, ph: ph, r: r});
      if (slots.size() > LAT) begin
        s       = slots.pop_front();
        exp_val = s.v;
        if (s.v) begin
          model(s.ph, s.r, mx, my, msat);
          exp_x = mx;
          exp_y = my;
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
          if (msat && exp_cnt < 65535) exp_cnt++;
`endif
        end
      end
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
      if (iclr) exp_cnt = 0;
`endif
    end
    check_eq("oval", oval, exp_val);
    check_eq("ox", ox, exp_x);
    check_eq("oy", oy, exp_y);
    check_eq("cos_addr", otab_cos_addr, exp_ca);
    check_eq("sin_addr", otab_sin_addr, exp_sa);
    check_eq("tab_clkena", otab_clkena, en);
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b0, 11'h000, 0);
  endtask

  task automatic clear_model();
    slots.delete();
    exp_val = 1'b0;
    exp_x   = 0;
    exp_y   = 0;
    exp_ca  = 0;
    exp_sa  = 0;
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    exp_cnt = 0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tab[i] = int'($floor(131072.0 * $cos(i * PI / 1022.0) + 0.5));
    ireset_n = 1'b0;
    iclkena  = 1'b0;
    ival     = 1'b0;
    iphase   = '0;
    iradius  = '0;
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    iclr     = 1'b0;
`endif
    clear_model();
    #12;
    check_eq("rst_oval", oval, 0);
    check_eq("rst_ox", ox, 0);
    check_eq("rst_oy", oy, 0);
    check_eq("rst_cos_addr", otab_cos_addr, 0);
    check_eq("rst_sin_addr", otab_sin_addr, 0);
    ireset_n = 1'b1;

    // Cardinal phases at unit radius.
    step(1'b1, 1'b1, 11'h000, 8192);
    check_eq("p0_cos_addr", otab_cos_addr, 0);
    check_eq("p0_sin_addr", otab_sin_addr, 511);
    drain();
    check_eq("p0_ox", ox, 2048);
    check_eq("p0_oy", oy, 0);
    step(1'b1, 1'b1, 11'h200, 8192);
    check_eq("p200_cos_addr", otab_cos_addr, 511);
    check_eq("p200_sin_addr", otab_sin_addr, 0);
    drain();
    check_eq("p200_ox", ox, 0);
    check_eq("p200_oy", oy, 2048);
    step(1'b1, 1'b1, 11'h400, 8192);
    drain();
    check_eq("p400_ox", ox, -2048);
    check_eq("p400_oy", oy, 0);

    // Full-scale radius saturates symmetrically.
    step(1'b1, 1'b1, 11'h000, 65535);
    drain();
    check_eq("sat_pos_ox", ox, DAT_MAX);
    step(1'b1, 1'b1, 11'h400, 65535);
    drain();
    check_eq("sat_neg_ox", ox, -DAT_MAX);
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    check_eq("sat_cnt_two", osat_cnt, 2);
    iclr = 1'b1;
    step(1'b1, 1'b0, 11'h000, 0);
    iclr = 1'b0;
    step(1'b1, 1'b0, 11'h000, 0);
    check_eq("sat_cnt_clr", osat_cnt, 0);
`endif

    // Zero radius with a gap in the valid pattern.
    step(1'b1, 1'b1, 11'($urandom), 0);
    step(1'b1, 1'b0, 11'($urandom), 0);
    step(1'b1, 1'b1, 11'($urandom), 0);
    drain();
    check_eq("r0_ox", ox, 0);
    check_eq("r0_oy", oy, 0);

    // Random stream with a three-clock stall in the middle.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom), 11'($urandom), int'(16'($urandom)));
      end
      step(1'b1, ($urandom_range(0, 7) != 0), 11'($urandom), int'(16'($urandom)));
    end
    step(1'b1, 1'b1, 11'h7FF, 8192);
    step(1'b1, 1'b1, 11'h000, 8192);
    drain();
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    check_eq("sat_cnt_stream", osat_cnt, exp_cnt);
`endif

    // Asynchronous reset between edges with samples in flight.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 11'($urandom), int'(16'($urandom)));
    #2;
    ireset_n = 1'b0;
    #1;
    check_eq("arst_oval", oval, 0);
    check_eq("arst_ox", ox, 0);
    check_eq("arst_oy", oy, 0);
    check_eq("arst_cos_addr", otab_cos_addr, 0);
    check_eq("arst_sin_addr", otab_sin_addr, 0);
`ifdef GAUS_CORDIC_MULT_SAT_CNT_EN
    check_eq("arst_sat_cnt", osat_cnt, 0);
`endif
    clear_model();
    #2;
    ireset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 11'($urandom), 8192);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 11'($urandom), int'(16'($urandom)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gaus_cordic_mult.md
Name: gaus_cordic_mult

Overview:
- Box-Muller output stage; sits directly around the quarter-wave cosine ROM (gaus_cordic_tab).
- Takes a uniform 11-bit phase and an unsigned radius sqrt(-2 ln u1) from the log/sqrt stage.
- Drives the ROM cos/sin addresses and folds the quarter-wave samples into full-circle signed cos/sin.
- Multiplies both by the radius and emits a rounded, saturated Gaussian pair (ox, oy) with a valid strobe.

Parameters:
- pTAB_LAT, 2: ROM read latency in clocks, from address register output to data.
- pRAD_W, 16: radius width, unsigned Q3.13.
- pDAT_W, 16: output sample width, signed.
- pSHIFT, 19: right shift applied to the Q1.17 x Q3.13 product before rounding.

Ports:
- iclk, in, 1: clock.
- ireset_n, in, 1: asynchronous active-low reset.
- iclkena, in, 1: global clock enable; stalls the whole pipeline.
- ival, in, 1: phase/radius valid.
- iphase, in, 11: phase; [10:9] = quadrant, [8:0] = quarter index a.
- iradius, in, pRAD_W: radius, unsigned.
- otab_clkena, out, 1: equals iclkena; drives the ROM iclkena.
- otab_cos_addr, out, 9: ROM cos address.
- otab_sin_addr, out, 9: ROM sin address.
- itab_cos, in, 18: ROM cos data, unsigned Q0.17.
- itab_sin, in, 18: ROM sin data, unsigned Q0.17.
- oval, out, 1: output pair valid.
- ox, out, pDAT_W: r*cos sample.
- oy, out, pDAT_W: r*sin sample.

Behaviour:
- Reset (async, ireset_n = 0):
  - All valid flags, oval, ox, oy, otab_cos_addr and otab_sin_addr clear to 0.
  - Any in-flight samples are discarded; no partial output after release.
- iclkena = 0: every register holds, including the valid shift chain. otab_clkena follows iclkena combinationally. A stall has no effect on data or ordering.
- Stage 1, registered on an edge with iclkena = 1:
  - Let na = 511 - a.
  - q = 0: cos address = a, sin address = na.
  - q = 1: cos address = na, sin address = a.
  - q = 2: cos address = a, sin address = na.
  - q = 3: cos address = na, sin address = a.
  - Quadrant, radius and valid enter a delay line pTAB_LAT deep, aligned with the ROM data.
- Stage 2, sign fold (19-bit signed):
  - cos is negated for q = 1 or 2.
  - sin is negated for q = 2 or 3.
  - Negating 0 yields 0.
- Stage 3, multiply: signed 19-bit x unsigned pRAD_W. The radius is zero-extended and the full-width product is registered.
- Stage 4, round and saturate:
  - Add 2^(pSHIFT-1), then arithmetic shift right by pSHIFT.
  - Symmetric saturation to +/-(2^(pDAT_W-1) - 1).
  - The result is registered into ox/oy, and oval is asserted.
- Latency: ival sampled on enabled edge k gives oval/ox/oy updated on enabled edge k + pTAB_LAT + 3 (5 clocks at default).
- Throughput: one pair per enabled clock. No backpressure; ival may be high on every clock.
- When ival = 0 the pipeline still advances. oval = 0 for that slot; ox/oy hold their last valid values.
- Phase wrap: 0x7FF is followed by 0x000 with no special handling.
- Radius 0 gives ox = oy = 0 for any phase.

Optional Feature:
- Macro: GAUS_CORDIC_MULT_SAT_CNT_EN.
- Defined:
  - Adds port iclr (in, 1) and port osat_cnt (out, 16).
  - osat_cnt counts output slots in which ox or oy saturated. It counts once per pair, only when oval is set and iclkena = 1.
  - The count sticks at 65535.
  - iclr is synchronous and clears the count; if iclr coincides with a saturation event, iclr wins.
  - Async reset clears the count to 0.
- Undefined: neither port exists and no counter logic is present. Datapath behaviour is identical in both builds.

Test Plan:
- Bench uses a behavioural ROM model with pTAB_LAT = 2.
- phase = 0x000, radius = 8192 (1.0) -> addresses cos = 0, sin = 511; after 5 clocks oval = 1, ox = 2048, oy = 0.
- phase = 0x200, radius = 8192 -> cos address = 511, sin address = 0; ox = 0, oy = 2048. Then phase = 0x400 -> ox = -2048, oy = 0.
- pDAT_W = 14, phase = 0x000, radius = 65535 -> ox = 8191 (saturated). Then phase = 0x400 -> ox = -8191. With the macro defined, osat_cnt = 2; iclr -> 0.
- Continuous stream of 1000 random phase/radius pairs, with iclkena low for 3 clocks mid-stream -> outputs match the golden model bit-exactly, in order, with no gaps other than the stall.
- Stream in flight, ireset_n pulsed low asynchronously between edges -> oval = 0, ox = oy = 0 and addresses = 0 immediately. The first oval after release comes 5 clocks after the first new ival.
- ival toggling 1,0,1 with radius = 0 -> oval pattern 1,0,1 delayed by 5 clocks; ox = oy = 0.
